trace_fifo: RTL and testbench

- Parametrised successor to the tracer's basic FIFO; buffers trace records between the kernel-side event capture and the trace drain/offload logic.
- Adds full-depth usage, including non-power-of-2 depths, plus occupancy count and programmable almost-full/almost-empty flags.
- Adds lossless-accounting overflow: a sticky flag and a saturating drop counter for records pushed while full.
- Adds a selectable output mode: first-word-fall-through (FWFT) or registered read.

---
 rtl/trace_fifo_pkg.sv | 13 +
 rtl/trace_fifo_ptr.sv | 35 +++
 rtl/trace_fifo.sv | 153 +++++++++++++++
 tb/tb_trace_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_fifo_pkg.sv
// Shared tracer package: FIFO output-mode constants and the
// occupancy-counter width helper used by trace_fifo and its bench.
package trace_fifo_pkg;

    localparam int FIFO_MODE_FWFT = 1;
    localparam int FIFO_MODE_REG  = 0;

    // Width needed to hold 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/trace_fifo_ptr.sv
// Wrap-at-Depth circular pointer with increment enable.
// Ports: clk, reset_n (sync, active-low), inc_i, ptr_o.
module trace_fifo_ptr #(
    parameter int Depth = 16,
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            inc_i,
    output logic [PtrW-1:0] ptr_o
);

    localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

    logic [PtrW-1:0] ptr_q, ptr_d;

    // Explicit wrap so non-power-of-2 depths use exactly Depth slots.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = (ptr_q == LastIdx) ? '0 : ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/trace_fifo.sv
// Trace-record FIFO: any depth >= 2, occupancy count, almost flags,
// sticky overflow with saturating drop counter, FWFT or registered read.
// Ports: clk, reset_n (sync, active-low); write side d/push/full/
// almost_full; read side pop/q/q_valid/empty/almost_empty; count;
// overflow/drop_count cleared by clear_ovf.
module trace_fifo
    import trace_fifo_pkg::*;
#(
    parameter int DataWidth         = 32,
    parameter int Depth             = 16,
    parameter int AlmostFullThresh  = Depth - 2,
    parameter int AlmostEmptyThresh = 2,
    parameter int Fwft              = FIFO_MODE_FWFT,
    parameter int DropCntWidth      = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DataWidth-1:0]         d,
    input  logic                         push,
    output logic                         full,
    output logic                         almost_full,
    input  logic                         pop,
    output logic [DataWidth-1:0]         q,
    output logic                         q_valid,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [clog2_cnt(Depth)-1:0]  count,
    output logic                         overflow,
    output logic [DropCntWidth-1:0]      drop_count,
    input  logic                         clear_ovf
);

    localparam int CntW = clog2_cnt(Depth);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    if (Depth < 2) begin : g_bad_depth
        $error("trace_fifo: Depth must be >= 2");
    end
    if (AlmostFullThresh > Depth || AlmostEmptyThresh > Depth) begin : g_bad_thr
        $error("trace_fifo: almost thresholds must not exceed Depth");
    end

    logic [DataWidth-1:0]    mem_q [Depth];
    logic [PtrW-1:0]         head, tail;
    logic [CntW-1:0]         count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic [DropCntWidth-1:0] drop_q, drop_d;
    logic                    push_acc, pop_acc, drop;

    // Flags come only from the registered count.
    assign full         = (count_q == CntW'(Depth));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CntW'(AlmostFullThresh));
    assign almost_empty = (count_q <= CntW'(AlmostEmptyThresh));

    // A pop frees the slot the same edge, so push-while-full is
    // accepted when paired with a real pop.
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);
    assign drop     = push && full && !pop_acc;

    trace_fifo_ptr #(.Depth(Depth)) u_head (
        .clk    (clk),
        .reset_n(reset_n),
        .inc_i  (push_acc),
        .ptr_o  (head)
    );

    trace_fifo_ptr #(.Depth(Depth)) u_tail (
        .clk    (clk),
        .reset_n(reset_n),
        .inc_i  (pop_acc),
        .ptr_o  (tail)
    );

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[head] <= d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_acc && !pop_acc) begin
            count_d = count_q + CntW'(1);
        end else if (!push_acc && pop_acc) begin
            count_d = count_q - CntW'(1);
        end
    end

    // A drop in the same cycle as clear_ovf wins and restarts at 1.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (clear_ovf) begin
                drop_d = DropCntWidth'(1);
            end else if (!(&drop_q)) begin
                drop_d = drop_q + DropCntWidth'(1);
            end
        end else if (clear_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign count      = count_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

    if (Fwft == FIFO_MODE_FWFT) begin : g_fwft
        assign q       = mem_q[tail];
        assign q_valid = !empty;
    end else begin : g_reg
        logic [DataWidth-1:0] rq_q, rq_d;
        logic                 rv_q, rv_d;

        always_comb begin
            rq_d = rq_q;
            rv_d = pop_acc;
            if (pop_acc) begin
                rq_d = mem_q[tail];
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rq_q <= '0;
                rv_q <= 1'b0;
            end else begin
                rq_q <= rq_d;
                rv_q <= rv_d;
            end
        end

        assign q       = rq_q;
        assign q_valid = rv_q;
    end

endmodule

// File: tb/tb_trace_fifo.sv
// Scoreboard bench for trace_fifo: three configurations, directed
// vectors, expected words queued at push and checked by a monitor.
module tb_trace_fifo;
    import trace_fifo_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: Depth=5 FWFT
    logic [31:0] a_d, a_q;
    logic        a_push, a_pop, a_clr;
    logic        a_full, a_af, a_qv, a_empty, a_ae, a_ovf;
    logic [2:0]  a_cnt;
    logic [15:0] a_dc;

    // B: Depth=4 registered read, 2-bit drop counter
    logic [31:0] b_d, b_q;
    logic        b_push, b_pop, b_clr;
    logic        b_full, b_af, b_qv, b_empty, b_ae, b_ovf;
    logic [2:0]  b_cnt;
    logic [1:0]  b_dc;

    // C: Depth=16 FWFT, AF=14 AE=2
    logic [31:0] c_d, c_q;
    logic        c_push, c_pop, c_clr;
    logic        c_full, c_af, c_qv, c_empty, c_ae, c_ovf;
    logic [4:0]  c_cnt;
    logic [15:0] c_dc;

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_c[$];

    trace_fifo #(.Depth(5), .Fwft(FIFO_MODE_FWFT)) u_a (
        .clk(clk), .reset_n(rst_n), .d(a_d), .push(a_push),
        .full(a_full), .almost_full(a_af), .pop(a_pop), .q(a_q),
        .q_valid(a_qv), .empty(a_empty), .almost_empty(a_ae),
        .count(a_cnt), .overflow(a_ovf), .drop_count(a_dc),
        .clear_ovf(a_clr)
    );

    trace_fifo #(.Depth(4), .Fwft(FIFO_MODE_REG), .DropCntWidth(2)) u_b (
        .clk(clk), .reset_n(rst_n), .d(b_d), .push(b_push),
        .full(b_full), .almost_full(b_af), .pop(b_pop), .q(b_q),
        .q_valid(b_qv), .empty(b_empty), .almost_empty(b_ae),
        .count(b_cnt), .overflow(b_ovf), .drop_count(b_dc),
        .clear_ovf(b_clr)
    );

    trace_fifo #(.Depth(16), .AlmostFullThresh(14),
                 .AlmostEmptyThresh(2), .Fwft(FIFO_MODE_FWFT)) u_c (
        .clk(clk), .reset_n(rst_n), .d(c_d), .push(c_push),
        .full(c_full), .almost_full(c_af), .pop(c_pop), .q(c_q),
        .q_valid(c_qv), .empty(c_empty), .almost_empty(c_ae),
        .count(c_cnt), .overflow(c_ovf), .drop_count(c_dc),
        .clear_ovf(c_clr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: FWFT words are consumed when pop meets q_valid;
    // registered-read words are presented when q_valid is high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_pop && a_qv) begin
                if (exp_a.size() == 0) chk("A_unexpected", 32'd1, 32'd0);
                else chk("A_q", a_q, exp_a.pop_front());
            end
            if (b_qv) begin
                if (exp_b.size() == 0) chk("B_unexpected", 32'd1, 32'd0);
                else chk("B_q", b_q, exp_b.pop_front());
            end
            if (c_pop && c_qv) begin
                if (exp_c.size() == 0) chk("C_unexpected", 32'd1, 32'd0);
                else chk("C_q", c_q, exp_c.pop_front());
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        {a_push, a_pop, a_clr} = '0;
        {b_push, b_pop, b_clr} = '0;
        {c_push, c_pop, c_clr} = '0;
        a_d = '0; b_d = '0; c_d = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_A_empty", 32'(a_empty), 32'd1);
        chk("rst_A_full", 32'(a_full), 32'd0);
        chk("rst_A_count", 32'(a_cnt), 32'd0);
        chk("rst_A_ae", 32'(a_ae), 32'd1);
        chk("rst_A_af", 32'(a_af), 32'd0);
        chk("rst_A_ovf", 32'(a_ovf), 32'd0);
        chk("rst_A_dc", 32'(a_dc), 32'd0);
        chk("rst_B_qv", 32'(b_qv), 32'd0);
        chk("rst_B_q", b_q, 32'd0);
        chk("rst_C_qv", 32'(c_qv), 32'd0);

        // Depth=5 fill A1..A5
        for (int i = 1; i <= 5; i++) begin
            a_d = 32'hA0 + 32'(i);
            a_push = 1'b1;
            exp_a.push_back(a_d);
            tick();
        end
        a_push = 1'b0;
        chk("A_full5", 32'(a_full), 32'd1);
        chk("A_count5", 32'(a_cnt), 32'd5);
        chk("A_af5", 32'(a_af), 32'd1);

        // Push while full with pop
        a_d = 32'hB0; a_push = 1'b1; a_pop = 1'b1;
        exp_a.push_back(32'hB0);
        tick();
        a_push = 1'b0; a_pop = 1'b0;
        chk("A_count_pp", 32'(a_cnt), 32'd5);
        chk("A_q_adv", a_q, 32'hA2);
        chk("A_ovf_pp", 32'(a_ovf), 32'd0);

        // Drain 5
        a_pop = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("A_empty_drain", 32'(a_empty), 32'd1);
        chk("A_count_drain", 32'(a_cnt), 32'd0);
        // Pop on empty ignored
        tick();
        chk("A_count_popempty", 32'(a_cnt), 32'd0);
        // Push+pop on empty: push only
        a_d = 32'hA7; a_push = 1'b1;
        exp_a.push_back(32'hA7);
        tick();
        a_push = 1'b0; a_pop = 1'b0;
        chk("A_count_pe", 32'(a_cnt), 32'd1);
        chk("A_q_pe", a_q, 32'hA7);
        a_pop = 1'b1;
        tick();
        a_pop = 1'b0;
        chk("A_empty_end", 32'(a_empty), 32'd1);

        // Depth=4 overflow accounting
        for (int i = 1; i <= 4; i++) begin
            b_d = 32'h30 + 32'(i);
            b_push = 1'b1;
            exp_b.push_back(b_d);
            tick();
        end
        chk("B_full", 32'(b_full), 32'd1);
        b_d = 32'hDD;
        for (int i = 0; i < 3; i++) tick();
        chk("B_ovf3", 32'(b_ovf), 32'd1);
        chk("B_dc3", 32'(b_dc), 32'd3);
        chk("B_count3", 32'(b_cnt), 32'd4);
        tick();
        chk("B_dc_sat", 32'(b_dc), 32'd3);
        b_d = 32'hEE; b_clr = 1'b1;
        tick();
        chk("B_ovf_clrdrop", 32'(b_ovf), 32'd1);
        chk("B_dc_clrdrop", 32'(b_dc), 32'd1);
        b_push = 1'b0;
        tick();
        b_clr = 1'b0;
        chk("B_ovf_clr", 32'(b_ovf), 32'd0);
        chk("B_dc_clr", 32'(b_dc), 32'd0);
        b_pop = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        b_pop = 1'b0;
        chk("B_q_last", b_q, 32'h34);
        tick();
        chk("B_qv_idle", 32'(b_qv), 32'd0);
        chk("B_q_hold", b_q, 32'h34);

        // Registered-read latency
        b_push = 1'b1;
        b_d = 32'h11; exp_b.push_back(b_d); tick();
        b_d = 32'h22; exp_b.push_back(b_d); tick();
        b_push = 1'b0;
        b_pop = 1'b1;
        chk("B_qv_pre", 32'(b_qv), 32'd0);
        tick();
        chk("B_qv_1", 32'(b_qv), 32'd1);
        chk("B_q_1", b_q, 32'h11);
        tick();
        chk("B_q_2", b_q, 32'h22);
        tick();
        chk("B_qv_emptypop", 32'(b_qv), 32'd0);
        chk("B_q_held", b_q, 32'h22);
        b_pop = 1'b0;

        // Depth=16 thresholds
        c_push = 1'b1;
        for (int i = 0; i < 13; i++) begin
            c_d = 32'hC000 + 32'(i);
            exp_c.push_back(c_d);
            tick();
        end
        chk("C_count13", 32'(c_cnt), 32'd13);
        chk("C_af13", 32'(c_af), 32'd0);
        c_d = 32'hC00D; exp_c.push_back(c_d);
        tick();
        chk("C_af14", 32'(c_af), 32'd1);
        for (int i = 14; i < 16; i++) begin
            c_d = 32'hC000 + 32'(i);
            exp_c.push_back(c_d);
            tick();
        end
        c_push = 1'b0;
        chk("C_full16", 32'(c_full), 32'd1);
        c_pop = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        c_pop = 1'b0;
        chk("C_count3", 32'(c_cnt), 32'd3);
        chk("C_ae3", 32'(c_ae), 32'd0);
        c_pop = 1'b1;
        tick();
        c_pop = 1'b0;
        chk("C_count2", 32'(c_cnt), 32'd2);
        chk("C_ae2", 32'(c_ae), 32'd1);

        // Mid-operation reset at count=3 with pop
        c_d = 32'hC0FF; c_push = 1'b1; exp_c.push_back(c_d);
        tick();
        c_push = 1'b0;
        chk("C_count_prerst", 32'(c_cnt), 32'd3);
        c_pop = 1'b1; rst_n = 1'b0;
        tick();
        exp_c.delete();
        c_pop = 1'b0; rst_n = 1'b1;
        chk("C_count_rst", 32'(c_cnt), 32'd0);
        chk("C_empty_rst", 32'(c_empty), 32'd1);
        chk("C_qv_rst", 32'(c_qv), 32'd0);
        chk("C_ovf_rst", 32'(c_ovf), 32'd0);
        c_d = 32'hC3; c_push = 1'b1; exp_c.push_back(c_d);
        tick();
        c_push = 1'b0;
        chk("C_q_first", c_q, 32'hC3);
        c_pop = 1'b1;
        tick();
        c_pop = 1'b0;
        tick();

        chk("A_left", 32'(exp_a.size()), 32'd0);
        chk("B_left", 32'(exp_b.size()), 32'd0);
        chk("C_left", 32'(exp_c.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
